// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache/memory types for the cacheline-to-burst adaptor.
// Line and beat geometry plus the adaptor's state encoding.
package cacheline_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;

    typedef logic [LINE_W-1:0]  line_t;
    typedef logic [BURST_W-1:0] burst_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns one whole-cacheline read/write into a 4-beat memory burst and
// answers upstream with a single resp_o pulse per completed line.
module cacheline_adaptor #(
    parameter int LINE_W  = cacheline_adaptor_pkg::LINE_W,
    parameter int BURST_W = cacheline_adaptor_pkg::BURST_W,
    parameter int ADDR_W  = cacheline_adaptor_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    import cacheline_adaptor_pkg::*;

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  buffer;
    logic [ADDR_W-1:0]  aligned_addr;
    logic               last_beat;

    assign aligned_addr = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign last_beat    = (cnt == CNT_W'(BEATS - 1));

    // Write wins when both requests are high; DONE always falls back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WRITE;
                end else if (read_i) begin
                    state_next = READ;
                end
            end
            READ, WRITE: begin
                if (resp_i && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            buffer    <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (write_i) begin
                        buffer    <= line_i;
                        address_o <= aligned_addr;
                    end else if (read_i) begin
                        address_o <= aligned_addr;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode from state alone, so no input reaches an output
    assign read_o  = (state == READ);
    assign write_o = (state == WRITE);
    assign resp_o  = (state == DONE);
    assign burst_o = (state == WRITE) ? buffer[int'(cnt)*BURST_W +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a memory-side responder plus a
// line-level model of what upstream should observe.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] model_line;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Strobe for cycle c: scripted pattern first, then random gaps, forced after 40 cycles
    function automatic logic strobe_at(input int c, input logic [15:0] pat, input int pat_len);
        if (c < pat_len) return pat[c];
        if (c >= 40) return 1'b1;
        return ($urandom_range(0, 2) != 0);
    endfunction

    task automatic run_read(input logic [31:0] addr, input logic [255:0] data,
                            input logic [15:0] pat, input int pat_len);
        int          k = 0;
        int          cyc = 0;
        logic        s;
        logic [31:0] al = addr & 32'hFFFF_FFE0;
        @(negedge clk);
        address_i = addr;
        read_i    = 1'b1;
        resp_i    = 1'b0;
        while (k < 4 && cyc < 64) begin
            @(negedge clk);
            chk("rd_read_o", read_o, 1);
            chk("rd_write_o", write_o, 0);
            chk("rd_resp_early", resp_o, 0);
            chk("rd_addr", address_o, al);
            s       = strobe_at(cyc, pat, pat_len);
            resp_i  = s;
            burst_i = s ? data[k*64 +: 64] : {$urandom, $urandom};
            if (s) k++;
            cyc++;
        end
        @(negedge clk);
        resp_i     = 1'b0;
        model_line = data;
        chk("rd_resp", resp_o, 1);
        chk("rd_read_o_done", read_o, 0);
        chk("rd_line", line_o, model_line);
        chk("rd_addr_done", address_o, al);
        @(negedge clk);
        chk("rd_resp_once", resp_o, 0);
        chk("rd_read_o_idle", read_o, 0);
        read_i = 1'b0;
        @(negedge clk);
        chk("rd_no_retrigger", {read_o, write_o, resp_o}, 3'b000);
        chk("rd_line_hold", line_o, model_line);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [255:0] data,
                             input logic both, input logic [15:0] pat, input int pat_len);
        int          k = 0;
        int          cyc = 0;
        logic        s;
        logic [31:0] al = addr & 32'hFFFF_FFE0;
        @(negedge clk);
        address_i = addr;
        line_i    = data;
        write_i   = 1'b1;
        read_i    = both;
        resp_i    = 1'b0;
        while (k < 4 && cyc < 64) begin
            @(negedge clk);
            chk("wr_write_o", write_o, 1);
            chk("wr_read_o", read_o, 0);
            chk("wr_resp_early", resp_o, 0);
            chk("wr_addr", address_o, al);
            chk("wr_burst", burst_o, data[k*64 +: 64]);
            line_i  = rand_line();
            s       = strobe_at(cyc, pat, pat_len);
            resp_i  = s;
            burst_i = {$urandom, $urandom};
            if (s) k++;
            cyc++;
        end
        @(negedge clk);
        resp_i = 1'b0;
        chk("wr_resp", resp_o, 1);
        chk("wr_outs_done", {read_o, write_o}, 2'b00);
        chk("wr_line_unchanged", line_o, model_line);
        @(negedge clk);
        chk("wr_resp_once", resp_o, 0);
        write_i = 1'b0;
        read_i  = 1'b0;
        @(negedge clk);
        chk("wr_no_retrigger", {read_o, write_o, resp_o}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0]  b0;
        logic [63:0]  b1;
        rst        = 1'b1;
        line_i     = '0;
        address_i  = '0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        burst_i    = '0;
        resp_i     = 1'b0;
        model_line = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_line_o", line_o, 0);
        chk("rst_burst_o", burst_o, 0);
        chk("rst_address_o", address_o, 0);
        chk("rst_ctl", {resp_o, read_o, write_o}, 3'b000);
        rst = 1'b0;

        // Stray memory strobes while idle
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            chk("idle_stray_ctl", {resp_o, read_o, write_o}, 3'b000);
            chk("idle_stray_line", line_o, model_line);
        end
        resp_i = 1'b0;

        run_read(32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'hFFFF, 16);
        run_write(32'h0000_5678, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b0, 16'hFFFF, 16);
        run_read(32'hABCD_EF1F, rand_line(), 16'h0059, 7);
        run_write(32'h0000_0040, rand_line(), 1'b1, 16'hFFFF, 16);

        // Reset after two read beats discards the partial line
        b0 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        @(negedge clk);
        address_i = 32'h0000_9999;
        read_i    = 1'b1;
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = b0;
        @(negedge clk);
        burst_i = b1;
        @(negedge clk);
        chk("rst_mid_partial", line_o, {model_line[255:128], b1, b0});
        resp_i = 1'b0;
        read_i = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctl", {resp_o, read_o, write_o}, 3'b000);
        chk("rst_mid_line", line_o, 0);
        rst        = 1'b0;
        model_line = '0;
        run_read(32'h0000_2000, rand_line(), 16'hFFFF, 16);

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 0)
                run_read($urandom, rand_line(), 16'h0000, 0);
            else
                run_write($urandom, rand_line(), 1'($urandom_range(0, 1)), 16'h0000, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the cache/arbiter line interface and the physical burst-memory port of the processor top level.
- Converts one 256-bit cacheline read or write into a 4-beat, 64-bit burst transaction.
- Presents a single-response, whole-line handshake to the upstream side.
- Latches the request, sequences the beats, and returns one resp pulse per completed line.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, width of one memory beat.
- ADDR_W, 32, address width.
- BEATS is derived as LINE_W/BURST_W (4). It is a localparam, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- line_i  in  LINE_W  write line from upstream.
- line_o  out  LINE_W  assembled read line; valid when resp_o=1.
- address_i  in  ADDR_W  upstream line address.
- read_i  in  1  upstream read request; held until resp_o.
- write_i  in  1  upstream write request; held until resp_o.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  burst address, line-aligned.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe; one beat per cycle it is high.

Behaviour:
- Reset values: line_o=0, resp_o=0, burst_o=0, address_o=0, read_o=0, write_o=0. Internal state is IDLE and beat counter cnt=0.
- States are IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state/cnt only; there is no combinational path from any input to any output.
- IDLE:
  - write_i=1 → latch line_i into the buffer; address_o={address_i[ADDR_W-1:5],5'b0}; cnt=0; go to WRITE.
  - Otherwise read_i=1 → latch the aligned address; cnt=0; go to READ.
  - If read_i and write_i are both high, the write wins (the combination is illegal upstream, but the outcome is defined).
  - resp_i in IDLE is ignored.
- READ:
  - read_o=1 for the whole state.
  - On each cycle with resp_i=1, store burst_i into line_o[cnt*BURST_W +: BURST_W] and increment cnt.
  - Gaps (resp_i=0) are allowed: hold cnt and read_o.
  - On the beat with cnt=BEATS-1, go to DONE. read_o drops in the first DONE cycle.
- WRITE:
  - write_o=1 for the whole state; burst_o=buffer[cnt*BURST_W +: BURST_W].
  - Beat 0 is present in the same cycle write_o first rises.
  - On resp_i=1, cnt increments and burst_o advances in the next cycle.
  - After the beat with cnt=BEATS-1, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, with read_o=write_o=0; line_o is stable.
  - Next state is IDLE unconditionally. Upstream deasserts its request the cycle after resp_o, so a request still high in the DONE cycle does not retrigger.
- Latency:
  - Request sampled in IDLE at cycle t → read_o/write_o high at t+1.
  - With back-to-back beats at t+1..t+4, resp_o is high at t+5.
  - Minimum 6-cycle turnaround including the return to IDLE.
- line_o holds its last value until the next read overwrites beats. A write does not modify line_o.
- cnt is $clog2(BEATS) bits and wraps to 0 after the final beat.
- Reset mid-operation:
  - Next edge returns to IDLE, read_o=write_o=0, cnt=0, resp_o=0.
  - A partial read line is discarded (line_o cleared).
- address_o holds its value through the transaction; it only changes when a new request is latched in IDLE.

Decomposition:
- Shared package (cache/memory types): LINE_W, BURST_W, ADDR_W constants; line_t/burst_t typedefs; the adaptor state enum.
- No sub-module: the beat counter and shift buffer stay inline. A single module is natural.

Test Plan:
- Read, back-to-back beats: address_i=0x0000_1234, read_i=1.
  - Expect address_o=0x0000_1220 and read_o=1 at t+1.
  - Memory supplies 0x11..11, 0x22..22, 0x33..33, 0x44..44 at t+1..t+4.
  - Expect resp_o=1 only at t+5 and line_o=0x44..44_33..33_22..22_11..11.
- Write: line_i=0xDDDD..._CCCC..._BBBB..._AAAA...
  - Expect write_o=1 with burst_o=0xAAAA... at the first write cycle.
  - Successive beats BBBB, CCCC, DDDD on resp_i.
  - One resp_o pulse; line_o unchanged.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1 → read_o stays high across gaps, beats land in order, resp_o one cycle after the 4th strobe.
- Simultaneous read_i=write_i=1 → write burst executes, read_o never asserts; held request after resp_o produces no second transaction.
- Reset after 2 read beats → next cycle read_o=0, resp_o=0, line_o=0. A fresh read then completes normally with cnt restarting at beat 0.
- Stray resp_i=1 while IDLE → no state change, no resp_o.
